// File: rtl/data_mem_ctrl.sv
// Data memory controller: 2^DEPTH_LOG2 x 32 RAM with fixed-latency byte/half/word access.
// Define DMEM_MISALIGN_EXC_EN to add the Misalign port and suppress misaligned accesses.
module data_mem_ctrl #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemWr,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Adr,
  input  logic [31:0] DataIn,
  output logic        Busy,
  output logic        Ready,
  output logic [31:0] DataOut
`ifdef DMEM_MISALIGN_EXC_EN
  ,
  output logic        Misalign
`endif
);

  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            w_accept, w_access, w_suppress;
  logic            r_wr, r_sext;
  logic [1:0]      r_size;
  logic [AW-1:0]   r_adr;
  logic [31:0]     r_din, r_dout;
  logic [31:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]     w_rword, w_wdata, w_load;
  logic [3:0]      w_be;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic            w_unused_adr;

  assign w_unused_adr = ^Adr[31:AW];

  // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: if (Req) begin
        w_accept    = 1'b1;
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = 4'(WAIT_CYCLES);
      end
      S_WAIT: if (r_cnt == 4'd0) begin
        w_access    = 1'b1;
        w_state_nxt = S_DONE;
      end else begin
        w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_adr   <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr   <= MemWr;
        r_size <= Size;
        r_sext <= SignExt;
        r_adr  <= Adr[AW-1:0];
        r_din  <= DataIn;
      end
    end
  end

`ifdef DMEM_MISALIGN_EXC_EN
  logic r_mis;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)         r_mis <= 1'b0;
    else if (w_accept) r_mis <= (Size == 2'b01 && Adr[0]) || (Size[1] && Adr[1:0] != 2'b00);
  end
  assign Misalign   = Ready & r_mis;
  assign w_suppress = r_mis;
`else
  assign w_suppress = 1'b0;
`endif

  assign w_idx   = r_adr[AW-1:2];
  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[8*r_adr[1:0] +: 8];
  assign w_half  = r_adr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_din;
    w_load  = w_rword;
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << r_adr[1:0];
        w_wdata = {4{r_din[7:0]}};
        w_load  = {{24{r_sext & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_be    = r_adr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_din[15:0]}};
        w_load  = {{16{r_sext & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

  // NOTE: the array has no reset so it maps to block RAM; its zero contents come from power-up init.
  always_ff @(posedge CLK) begin
    if (w_access && r_wr && !w_suppress) begin
      for (int n = 0; n < 4; n++)
        if (w_be[n]) r_mem[w_idx][8*n +: 8] <= w_wdata[8*n +: 8];
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                                  r_dout <= '0;
    else if (w_access && !r_wr && !w_suppress)  r_dout <= w_load;
  end

  assign Busy    = (r_state != S_IDLE);
  assign Ready   = (r_state == S_DONE);
  assign DataOut = r_dout;

endmodule
